// File: rtl/lsu_mem_master.sv
// Single-outstanding load/store master: word-aligns the request, drives byte
// strobes, waits for the memory ack with a timeout, and returns extended load data.
module lsu_mem_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      r_state, w_next;
  logic        r_wr, r_signed, r_err;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [1:0]  r_size;
  logic [7:0]  r_cnt;

  logic        w_bad;
  logic        w_tmo;
  logic [31:0] w_shift, w_ext, w_wdata;
  logic [3:0]  w_wstrb;

  assign w_bad = (req_size == 2'd3) ||
                 (req_size == 2'd1 && req_addr[0]) ||
                 (req_size == 2'd2 && req_addr[1:0] != 2'b00);
  assign w_tmo = (r_cnt == 8'(TIMEOUT));

  assign w_shift = mem_rdata >> {r_addr[1:0], 3'b000};
  always_comb begin
    w_ext = w_shift;
    case (r_size)
      2'd0:    w_ext = {{24{r_signed & w_shift[7]}},  w_shift[7:0]};
      2'd1:    w_ext = {{16{r_signed & w_shift[15]}}, w_shift[15:0]};
      default: w_ext = w_shift;
    endcase
  end

  // Narrow stores are replicated across all lanes; the strobes pick the live ones.
  always_comb begin
    w_wdata = r_wdata;
    w_wstrb = 4'b1111;
    case (r_size)
      2'd0: begin
        w_wdata = {4{r_wdata[7:0]}};
        w_wstrb = 4'b0001 << r_addr[1:0];
      end
      2'd1: begin
        w_wdata = {2{r_wdata[15:0]}};
        w_wstrb = 4'b0011 << r_addr[1:0];
      end
      default: begin
        w_wdata = r_wdata;
        w_wstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (req_valid) w_next = w_bad ? RESP : REQ;
      REQ:  w_next = WAIT;
      WAIT: if (mem_rvalid || w_tmo) w_next = RESP;
      RESP: if (resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_wr     <= 1'b0;
      r_signed <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_size   <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (req_valid) begin
          r_wr     <= req_wr;
          r_addr   <= req_addr;
          r_wdata  <= req_wdata;
          r_size   <= req_size;
          r_signed <= req_signed;
          r_err    <= w_bad;
          r_rdata  <= '0;
        end
        REQ: r_cnt <= '0;
        WAIT: begin
          // An ack in the timeout cycle still completes the access cleanly.
          if (mem_rvalid)  r_rdata <= r_wr ? 32'd0 : w_ext;
          else if (w_tmo)  r_err   <= 1'b1;
          else             r_cnt   <= r_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_err   = (r_state == RESP) && r_err;
  assign resp_rdata = (r_state == RESP) ? r_rdata : 32'd0;
  assign mem_en     = (r_state == REQ);
  assign mem_wr     = (r_state == REQ) && r_wr;
  assign mem_addr   = (r_state == REQ) ? {r_addr[31:2], 2'b00} : 32'd0;
  assign mem_wdata  = (r_state == REQ) ? w_wdata : 32'd0;
  assign mem_wstrb  = (r_state == REQ && r_wr) ? w_wstrb : 4'b0000;
endmodule

// File: tb/tb_lsu_mem_master.sv
// Randomized bench for lsu_mem_master against a byte-level reference model.
module tb_lsu_mem_master;
  localparam int T = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_wr = 1'b0, req_signed = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_ready, resp_valid, resp_err;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        mem_en, mem_wr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;

  int total = 0;
  int bad   = 0;

  lsu_mem_master #(.TIMEOUT(T)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_signed(req_signed),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: treat words as byte arrays.
  function automatic logic [31:0] m_load(input logic [31:0] rd, input int o,
                                         input int n, input bit sg);
    logic [31:0] v;
    v = 0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(o+i) +: 8];
    if (sg && v[8*n-1])
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] wd, input int n);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = wd[8*(i % n) +: 8];
    return v;
  endfunction

  function automatic logic [3:0] m_wstrb(input int o, input int n);
    logic [3:0] v;
    v = 0;
    for (int i = 0; i < 4; i++) v[i] = (i >= o) && (i < o + n);
    return v;
  endfunction

  function automatic logic [31:0] m_rand32();
    logic [31:0] v;
    v = $urandom;
    return v;
  endfunction

  // ack_cyc: cycle (accept = 0) in which mem_rvalid is driven; out of range = no ack.
  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] sz, input logic sg, input int ack_cyc,
                        input logic [31:0] rd, input int hold);
    int n, o, exp_cyc, got_cyc, en_cnt;
    bit legal, acked, exp_err;
    logic [31:0] exp_data;
    n = 1 << sz;
    o = int'(addr[1:0]);
    legal   = (sz != 2'd3) && (o % n == 0);
    acked   = legal && ack_cyc >= 2 && ack_cyc <= 2 + T;
    exp_err = !acked;
    exp_cyc = !legal ? 1 : (acked ? ack_cyc + 1 : 3 + T);
    exp_data = (exp_err || wr) ? 32'd0 : m_load(rd, o, n, sg);

    @(negedge clock);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wd;
    req_size = sz; req_signed = sg; resp_ready = 1'b0;
    @(posedge clock); #1;
    req_valid = 1'b0; req_wr = $urandom_range(1); req_addr = m_rand32();
    req_wdata = m_rand32(); req_size = 2'($urandom_range(3));

    got_cyc = -1; en_cnt = 0;
    for (int c = 1; c <= 3 + T + 4 && got_cyc < 0; c++) begin
      @(negedge clock);
      if (mem_en) begin
        en_cnt++;
        chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
        chk("mem_wr", {31'd0, mem_wr}, {31'd0, wr});
        chk("mem_wstrb", {28'd0, mem_wstrb}, wr ? {28'd0, m_wstrb(o, n)} : 32'd0);
        if (wr) chk("mem_wdata", mem_wdata, m_wdata(wd, n));
      end
      if (resp_valid) got_cyc = c;
      else chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
      // A pulse during REQ must be ignored.
      mem_rvalid = (c == ack_cyc) || (c == 1 && $urandom_range(1) == 1);
      mem_rdata  = (c == ack_cyc) ? rd : m_rand32();
    end
    mem_rvalid = 1'b0;
    chk("resp_cycle", got_cyc, exp_cyc);
    chk("mem_en_count", en_cnt, legal ? 1 : 0);
    chk("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
    chk("resp_rdata", resp_rdata, exp_data);

    for (int h = 0; h < hold; h++) begin
      mem_rvalid = $urandom_range(1); mem_rdata = m_rand32();
      @(negedge clock);
      chk("hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_err", {31'd0, resp_err}, {31'd0, exp_err});
      chk("hold_rdata", resp_rdata, exp_data);
      chk("hold_ready", {31'd0, req_ready}, 32'd0);
      chk("hold_mem_en", {31'd0, mem_en}, 32'd0);
    end
    mem_rvalid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    chk("post_valid", {31'd0, resp_valid}, 32'd0);
    chk("post_ready", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_resp"}, {30'd0, resp_valid, resp_err}, 32'd0);
    chk({tag, "_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_mem_ctl"}, {30'd0, mem_en, mem_wr}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_mem_wstrb"}, {28'd0, mem_wstrb}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk_reset_outputs("reset");
    reset = 1'b0;

    // Directed cases.
    access(1'b0, 32'h8000_0004, 32'h0, 2'd2, 1'b0, 3, 32'hDEAD_BEEF, 0);
    access(1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b1, 2, 32'h80FF_7F01, 0);
    access(1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b0, 2, 32'h80FF_7F01, 0);
    access(1'b0, 32'h8000_0002, 32'h0, 2'd1, 1'b1, 4, 32'h80FF_7F01, 1);
    access(1'b1, 32'h8000_0002, 32'h1234, 2'd1, 1'b0, 3, 32'hFFFF_FFFF, 0);
    access(1'b0, 32'h8000_0001, 32'h0, 2'd2, 1'b0, 3, 32'h1111_1111, 0);
    access(1'b0, 32'h8000_0000, 32'h0, 2'd3, 1'b0, 3, 32'h1111_1111, 0);
    access(1'b0, 32'h8000_0000, 32'h0, 2'd2, 1'b0, -1, 32'h0, 3);
    access(1'b0, 32'h8000_0008, 32'h0, 2'd2, 1'b1, 2 + T, 32'hCAFE_F00D, 0);
    access(1'b1, 32'h8000_0001, 32'hA5A5_A5C3, 2'd0, 1'b0, 2, 32'h0, 0);

    // Reset while waiting for the ack; the late ack must be ignored.
    @(negedge clock);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h8000_0010; req_size = 2'd2;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    chk_reset_outputs("midrst");
    @(negedge clock);
    mem_rvalid = 1'b0;
    chk_reset_outputs("after_ack");
    @(negedge clock);
    chk_reset_outputs("after_ack2");
    access(1'b0, 32'h8000_0010, 32'h0, 2'd2, 1'b0, 3, 32'h0BAD_F00D, 0);

    // Randomized accesses, mostly legal.
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      a  = 32'h8000_0000 | (m_rand32() & 32'h0000_0FFF);
      sz = ($urandom_range(9) == 0) ? 2'd3 : 2'($urandom_range(2));
      if ($urandom_range(3) != 0 && sz != 2'd3)
        a[1:0] = (sz == 2'd2) ? 2'b00 : (sz == 2'd1 ? {a[1], 1'b0} : a[1:0]);
      access($urandom_range(1) == 1, a, m_rand32(), sz, $urandom_range(1) == 1,
             int'($urandom_range(T + 4, 1)), m_rand32(), int'($urandom_range(2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Initiator side of the core's physical-memory port: accepts one load/store at a time from the execute stage, converts it into a word-aligned memory request with byte strobes, waits for the memory's acknowledge, and returns aligned, sign- or zero-extended load data. It sits between the pipeline's LSU handshake and the DPI-backed memory responder. It also detects misaligned or illegal-size accesses and memory timeouts, and reports them as errors.

## Interface
- TIMEOUT, 255: WAIT cycles without `mem_rvalid` before the access is aborted with an error; counter is 8 bits.
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  pipeline request valid
- req_ready  out  1  block can accept a request
- req_wr  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_signed  in  1  sign-extend load result
- resp_valid  out  1  response valid
- resp_ready  in  1  pipeline accepts response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, illegal size or timeout
- mem_en  out  1  memory request strobe, one cycle per access
- mem_wr  out  1  1 = write
- mem_addr  out  32  `{req_addr[31:2], 2'b00}`
- mem_wdata  out  32  lane-shifted store data
- mem_wstrb  out  4  byte-lane write enables; 0 on reads
- mem_rdata  in  32  read word, sampled when `mem_rvalid` is high
- mem_rvalid  in  1  memory acknowledge (reads and writes)

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, latch all request fields.
  - If `req_size` = 3, or half with `addr[0]` = 1, or word with `addr[1:0]` ≠ 0: set the error flag and go to RESP. No memory access is made.
  - Otherwise go to REQ.
- REQ:
  - `mem_en` = 1 for exactly this cycle; `mem_wr`, `mem_addr`, `mem_wdata`, `mem_wstrb` are driven from the latched fields.
  - Clear the timeout counter; go to WAIT.
- WAIT:
  - On `mem_rvalid`: capture `mem_rdata`; go to RESP.
  - Otherwise increment the counter. When the counter equals TIMEOUT, set the error flag and go to RESP.
  - A `mem_rvalid` in the same cycle as the timeout wins: no error.
- RESP:
  - `resp_valid` = 1. All response outputs stay stable until `resp_ready`; then go to IDLE.
- Store lanes, with `o = addr[1:0]`:
  - byte: `mem_wdata = {4{wdata[7:0]}}`, `mem_wstrb = 4'b0001 << o`.
  - half: `mem_wdata = {2{wdata[15:0]}}`, `mem_wstrb = 4'b0011 << o`.
  - word: `mem_wdata = wdata`, `mem_wstrb = 4'b1111`.
- Load extract: `s = mem_rdata >> (8*o)`.
  - byte: `s[7:0]` extended.
  - half: `s[15:0]` extended.
  - word: `s`.
  - Extension is sign or zero according to `req_signed`.
- `mem_rvalid` outside WAIT is ignored.
- `req_valid` outside IDLE is ignored; `req_ready` = 0 there.

## Timing
- Reset: state IDLE; counter 0; outputs as follows:
  - `req_ready` = 1
  - `resp_valid` = 0, `resp_err` = 0, `resp_rdata` = 0
  - `mem_en` = 0, `mem_wr` = 0
  - `mem_addr` = 0, `mem_wdata` = 0, `mem_wstrb` = 0
- Reset mid-access returns to IDLE next edge with the values above. No `mem_en` is issued after reset.
- Cycle numbering:
  - Acceptance edge = cycle 0.
  - `mem_en` high in cycle 1.
  - `mem_rvalid` is sampled from cycle 2.
  - If `mem_rvalid` is high in cycle k, `resp_valid` is high from cycle k+1.
  - Minimum latency from accept to `resp_valid`: 3 cycles.
- Error paths:
  - Misaligned / illegal size: `resp_valid` in cycle 1, `mem_en` never asserted.
  - Timeout: `resp_valid` in cycle 2+TIMEOUT+1 when no ack arrives.
- Throughput: one access outstanding. With `resp_ready` held high, the next request can be accepted in the cycle after the response handshake.
- All outputs are registered or decoded from state and latched fields; none is combinational from inputs.

## Test plan
- Load word at 0x80000004, `mem_rdata` = 0xDEADBEEF, ack 2 cycles after `mem_en` → `mem_addr` = 0x80000004, `mem_wstrb` = 0, `resp_rdata` = 0xDEADBEEF, `resp_err` = 0, `resp_valid` 4 cycles after accept.
- Signed byte load at 0x80000003, `mem_rdata` = 0x80FF7F01 → `resp_rdata` = 0xFFFFFF80. Same access unsigned → 0x00000080. Signed half at offset 2 → 0xFFFF80FF.
- Store half 0x1234 at 0x80000002 → `mem_en` one cycle, `mem_wr` = 1, `mem_addr` = 0x80000000, `mem_wstrb` = 0b1100, `mem_wdata` = 0x12341234. After ack: `resp_rdata` = 0, `resp_err` = 0.
- Word load at 0x80000001, and separately `req_size` = 3 → no `mem_en`; `resp_valid` + `resp_err` = 1 in the cycle after accept.
- TIMEOUT = 4 with no ack → `resp_err` = 1 after 4 WAIT cycles. Then hold `resp_ready` = 0 for 3 cycles → response stable and `req_ready` = 0. Then release → back to IDLE.
- Assert `reset` while in WAIT, then ack → the ack is ignored and all outputs return to reset values. The next load completes normally.
